// File: rtl/versat_seq_mux_pkg.sv
// Shared types and mode encodings for the sequenced N-input multiplexer unit.
package versat_seq_mux_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StActive
  } state_e;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_SWEEP  = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;

endpackage

// File: rtl/versat_cnt.sv
// Loadable down-counter with zero flag; load has priority over enable.
module versat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/versat_seq_mux.sv
// Sequenced N-input multiplexer: static, round-robin sweep or step-driven selection
// onto a registered output, under the run/running/done unit protocol.
module versat_seq_mux
  import versat_seq_mux_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SEL_W  = $clog2(N_IN),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   running,
  output logic                   done,
  input  logic [N_IN*DATA_W-1:0] in,
  output logic [DATA_W-1:0]      out0,
  input  logic [SEL_W-1:0]       sel_cfg,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       delay,
  input  logic [CNT_W-1:0]       period,
  input  logic [CNT_W-1:0]       iter,
  input  logic                   step
);

  localparam logic [SEL_W-1:0] MaxSel = SEL_W'(N_IN - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    per_rel_q, per_rel_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   out0_q, sel_data;

  logic [SEL_W-1:0]    sel_start, sel_wrap;
  logic [CNT_W-1:0]    per_eff;

  logic                dly_load, dly_en, dly_zero;
  logic [CNT_W-1:0]    dly_val;
  logic                per_load, per_en, per_zero;
  logic [CNT_W-1:0]    per_val;
  logic                it_load, it_en, it_zero;
  logic [CNT_W-1:0]    it_val;

  // Out-of-range start selections clamp to the last input.
  assign sel_start = ({1'b0, sel_cfg} > {1'b0, MaxSel}) ? MaxSel : sel_cfg;
  assign sel_wrap  = (cur_sel_q >= MaxSel) ? '0 : cur_sel_q + SEL_W'(1);
  // Counters hold reload-1 so the zero flag marks the last cycle of each interval.
  assign per_eff   = (period == '0) ? '0 : period - CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    mode_d    = mode_q;
    per_rel_d = per_rel_q;
    done_d    = 1'b0;
    dly_load  = 1'b0;
    dly_val   = '0;
    dly_en    = 1'b0;
    per_load  = 1'b0;
    per_val   = per_rel_q;
    per_en    = 1'b0;
    it_load   = 1'b0;
    it_val    = '0;
    it_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          cur_sel_d = sel_start;
          mode_d    = mode;
          per_rel_d = per_eff;
          per_load  = 1'b1;
          per_val   = per_eff;
          it_load   = 1'b1;
          it_val    = iter - CNT_W'(1);
          dly_load  = 1'b1;
          dly_val   = delay - CNT_W'(1);
          if (iter == '0) begin
            done_d = 1'b1;
          end else if (delay == '0) begin
            state_d = StActive;
          end else begin
            state_d = StDelay;
          end
        end
      end

      StDelay: begin
        if (dly_zero) begin
          state_d = StActive;
        end else begin
          dly_en = 1'b1;
        end
      end

      StActive: begin
        if (it_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          it_en = 1'b1;
        end

        case (mode_q)
          MODE_SWEEP: begin
            if (per_zero) begin
              per_load = 1'b1;
              // A period boundary on the final cycle does not advance the selection.
              if (!it_zero) begin
                cur_sel_d = sel_wrap;
              end
            end else begin
              per_en = 1'b1;
            end
          end
          MODE_STEP: begin
            if (step) begin
              cur_sel_d = sel_wrap;
            end
          end
          default: ;
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cur_sel_q <= '0;
      mode_q    <= MODE_STATIC;
      per_rel_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      mode_q    <= mode_d;
      per_rel_q <= per_rel_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (cur_sel_q == SEL_W'(k)) begin
        sel_data = in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0_q <= '0;
    end else begin
      out0_q <= sel_data;
    end
  end

  versat_cnt #(
    .CNT_W(CNT_W)
  ) u_dly_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (dly_load),
    .load_val_i(dly_val),
    .en_i      (dly_en),
    .zero_o    (dly_zero)
  );

  versat_cnt #(
    .CNT_W(CNT_W)
  ) u_per_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (per_load),
    .load_val_i(per_val),
    .en_i      (per_en),
    .zero_o    (per_zero)
  );

  versat_cnt #(
    .CNT_W(CNT_W)
  ) u_it_cnt (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (it_load),
    .load_val_i(it_val),
    .en_i      (it_en),
    .zero_o    (it_zero)
  );

  assign running = (state_q != StIdle);
  assign done    = done_q;
  assign out0    = out0_q;

endmodule

// File: tb/tb_versat_seq_mux.sv
// Randomised and directed bench for versat_seq_mux against a schedule-based reference model.
module tb_versat_seq_mux;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int SW = 3;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              running;
  logic              done;
  logic [NI*DW-1:0]  in_v = '0;
  logic [DW-1:0]     out0;
  logic [SW-1:0]     sel_cfg = '0;
  logic [1:0]        mode = '0;
  logic [CW-1:0]     delay = '0;
  logic [CW-1:0]     period = '0;
  logic [CW-1:0]     iter = '0;
  logic              step = 1'b0;

  always #5 clk = ~clk;

  versat_seq_mux #(
    .DATA_W(DW),
    .N_IN  (NI),
    .SEL_W (SW),
    .CNT_W (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .running(running),
    .done   (done),
    .in     (in_v),
    .out0   (out0),
    .sel_cfg(sel_cfg),
    .mode   (mode),
    .delay  (delay),
    .period (period),
    .iter   (iter),
    .step   (step)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: the latest accepted run's configuration and its start cycle.
  bit   act = 1'b0;
  int   m_t0, m_d, m_i, m_p, m_mode, m_sel0;
  bit   steps [0:63];
  int   sel_n = 0;
  logic [DW-1:0] exp_out_next = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input logic [NI*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic bit exp_running(input int n);
    return act && (m_i > 0) && (n > m_t0) && (n <= m_t0 + m_d + m_i);
  endfunction

  function automatic bit exp_done(input int n);
    return act && (n == m_t0 + m_d + m_i + 1);
  endfunction

  // Selection in cycle n, from how many advances the run's rules allow before n.
  function automatic int exp_sel(input int n);
    int k, a, last, c;
    if (!act) return 0;
    k = n - m_t0;
    if (m_i == 0 || k <= m_d) return m_sel0;
    a = k - m_d;
    last = (a <= m_i) ? a - 1 : m_i;
    c = 0;
    if (m_mode == 1) begin
      c = (a <= m_i) ? (a - 1) / m_p : (m_i - 1) / m_p;
    end else if (m_mode == 2) begin
      for (int j = 1; j <= last; j++) c += int'(steps[j]);
    end
    return (m_sel0 + c) % NI;
  endfunction

  // Drive one cycle of inputs, advance the model, then check the next cycle's outputs.
  task automatic tick(input bit r, input int s, input int md, input int d, input int p,
                      input int it, input bit st);
    int a;
    run     = r;
    sel_cfg = SW'(s);
    mode    = 2'(md);
    delay   = CW'(d);
    period  = CW'(p);
    iter    = CW'(it);
    step    = st;
    if (act && m_i > 0) begin
      a = cyc - m_t0 - m_d;
      if (a >= 1 && a <= m_i) steps[a] = st;
    end
    exp_out_next = word_of(in_v, sel_n);
    if (r && !exp_running(cyc)) begin
      act    = 1'b1;
      m_t0   = cyc;
      m_i    = it;
      m_d    = (it == 0) ? 0 : d;
      m_p    = (p == 0) ? 1 : p;
      m_mode = md;
      m_sel0 = (s >= NI) ? NI - 1 : s;
      for (int j = 0; j < 64; j++) steps[j] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    sel_n = exp_sel(cyc);
    check_eq("running", 64'(running), 64'(exp_running(cyc)));
    check_eq("done", 64'(done), 64'(exp_done(cyc)));
    check_eq("out0", 64'(out0), 64'(exp_out_next));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out0", 64'(out0), 64'd0);
    check_eq("rst_running", 64'(running), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst   = 1'b1;
    act   = 1'b0;
    sel_n = 0;
  endtask

  initial begin
    in_v = {$urandom, $urandom, $urandom, $urandom};
    do_reset();

    // Static selection, then clamp of an out-of-range start select.
    in_v = {32'd40, 32'd30, 32'd20, 32'd10};
    tick(1'b1, 2, 0, 0, 0, 3, 1'b0);
    idle(4);
    check_eq("static_hold", 64'(out0), 64'd30);
    tick(1'b1, 7, 0, 0, 0, 3, 1'b0);
    idle(4);
    check_eq("clamp_hold", 64'(out0), 64'd40);

    // Sweep with wrap: 3,3,0,0,1,1,2,2.
    tick(1'b1, 3, 1, 2, 2, 8, 1'b0);
    idle(11);

    // Step: pulse in DELAY (ignored) and in ACTIVE cycles 2 and 4.
    tick(1'b1, 0, 2, 2, 0, 5, 1'b0);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b1);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b0);
    tick(1'b0, 0, 0, 0, 0, 0, 1'b1);
    idle(3);

    // iter=0 finishes at once; period=0 sweeps every cycle.
    tick(1'b1, 1, 0, 3, 1, 0, 1'b0);
    idle(2);
    tick(1'b1, 0, 1, 0, 0, 6, 1'b0);
    idle(7);

    // Run while running is ignored; run in the done cycle is accepted.
    tick(1'b1, 1, 0, 1, 0, 4, 1'b0);
    tick(1'b1, 2, 1, 0, 1, 5, 1'b0);
    idle(4);
    tick(1'b1, 3, 0, 0, 0, 2, 1'b0);
    idle(4);

    // Abort mid-ACTIVE with varying inputs, then a fresh run.
    for (int i = 0; i < 2; i++) begin
      in_v = {$urandom, $urandom, $urandom, $urandom};
      tick(1'b1, 1, 1, 1, 1, 10, 1'b0);
      for (int j = 0; j < 4; j++) begin
        in_v = {$urandom, $urandom, $urandom, $urandom};
        tick(1'b0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      end
      #2 rst = 1'b0;
      #1;
      check_eq("abort_out0", 64'(out0), 64'd0);
      check_eq("abort_running", 64'(running), 64'd0);
      check_eq("abort_done", 64'(done), 64'd0);
      act   = 1'b0;
      sel_n = 0;
      @(posedge clk);
      #1;
      check_eq("abort_hold_done", 64'(done), 64'd0);
      rst = 1'b1;
      tick(1'b1, 2, 1, 1, 1, 4, 1'b0);
      idle(7);
    end

    // Random traffic: overlapping runs, mid-run config churn, random steps and data.
    for (int i = 0; i < 1500; i++) begin
      in_v = {$urandom, $urandom, $urandom, $urandom};
      tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
